// File: rtl/barrel_shift_register.sv
// Registered 8-bit barrel rotator (left/right by 0..WIDTH-1); 1-cycle latency.
// No handshake: a new result is captured every cycle, so it never stalls.
module barrel_shift_register #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    output logic [WIDTH-1:0] outp
);

    logic [WIDTH-1:0] pre_dat;
    logic [WIDTH-1:0] rot_dat;
    logic [WIDTH-1:0] post_dat;
    logic [WIDTH-1:0] stage_dat [0:SHW];

    // Right rotation is a left rotation of the bit-reversed word, reversed back.
    always_comb begin
        pre_dat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pre_dat[i] = dir ? inp[WIDTH-1-i] : inp[i];
        end
    end

    assign stage_dat[0] = pre_dat;

    for (genvar j = 0; j < SHW; j++) begin : g_stage
        localparam int S = 1 << j;
        assign stage_dat[j+1] = shamt[j]
            ? {stage_dat[j][WIDTH-1-S:0], stage_dat[j][WIDTH-1:WIDTH-S]}
            : stage_dat[j];
    end

    assign rot_dat = stage_dat[SHW];

    always_comb begin
        post_dat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            post_dat[i] = dir ? rot_dat[WIDTH-1-i] : rot_dat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outp <= '0;
        end else begin
            outp <= post_dat;
        end
    end

endmodule

// File: tb/tb_barrel_shift_register.sv
// Bench for barrel_shift_register: directed vector table, mid-cycle hold sequence,
// and randomized sweep against an index-arithmetic rotation model.
module tb_barrel_shift_register;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] inp;
    logic [SHW-1:0]   shamt;
    logic             dir;
    logic [WIDTH-1:0] outp;

    int checks   = 0;
    int failures = 0;

    barrel_shift_register #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst   (rst),
        .inp   (inp),
        .shamt (shamt),
        .dir   (dir),
        .outp  (outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst;
        logic [WIDTH-1:0] inp;
        logic [SHW-1:0]   shamt;
        logic             dir;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(string n, logic r, logic [WIDTH-1:0] d,
                                logic [SHW-1:0] k, logic dr, logic [WIDTH-1:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.inp = d; v.shamt = k; v.dir = dr; v.exp = e;
        return v;
    endfunction

    // Reference: each output bit is picked from its source index modulo WIDTH.
    function automatic logic [WIDTH-1:0] model_rot(logic [WIDTH-1:0] d, int k, logic dr);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dr) r[i] = d[(i + k) % WIDTH];
            else    r[i] = d[(i - k + WIDTH) % WIDTH];
        end
        return r;
    endfunction

    task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outp=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] d;
        logic             r;
        int               k;

        rst = 1'b1; inp = '0; shamt = '0; dir = 1'b0;

        vecs.push_back(mk("reset",          1'b1, 8'hDB, 3'd5, 1'b0, 8'h00));
        vecs.push_back(mk("post_reset",     1'b0, 8'hDB, 3'd5, 1'b0, 8'h7B));
        vecs.push_back(mk("identity_left",  1'b0, 8'hDB, 3'd0, 1'b0, 8'hDB));
        vecs.push_back(mk("identity_right", 1'b0, 8'hDB, 3'd0, 1'b1, 8'hDB));
        vecs.push_back(mk("rotl5",          1'b0, 8'hDB, 3'd5, 1'b0, 8'h7B));
        vecs.push_back(mk("rotr5",          1'b0, 8'hDB, 3'd5, 1'b1, 8'hDE));
        vecs.push_back(mk("wrap_l1",        1'b0, 8'h80, 3'd1, 1'b0, 8'h01));
        vecs.push_back(mk("wrap_r1",        1'b0, 8'h01, 3'd1, 1'b1, 8'h80));
        vecs.push_back(mk("wrap_l7",        1'b0, 8'h01, 3'd7, 1'b0, 8'h80));
        vecs.push_back(mk("rotr7",          1'b0, 8'h01, 3'd7, 1'b1, 8'h02));
        vecs.push_back(mk("rotl4",          1'b0, 8'hA5, 3'd4, 1'b0, 8'h5A));
        vecs.push_back(mk("midstream_rst",  1'b1, 8'hFF, 3'd3, 1'b1, 8'h00));
        vecs.push_back(mk("after_rst",      1'b0, 8'h0F, 3'd2, 1'b0, 8'h3C));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; inp = vecs[i].inp;
            shamt = vecs[i].shamt; dir = vecs[i].dir;
            tick();
            check(vecs[i].name, outp, vecs[i].exp);
        end

        // Inputs toggling between edges must not disturb the registered output.
        rst = 1'b0; inp = 8'hC3; shamt = 3'd2; dir = 1'b1;
        tick();
        held = 8'hF0;
        check("hold_load", outp, held);
        inp = 8'h12; shamt = 3'd6; dir = 1'b0;
        #2 check("hold_mid1", outp, held);
        inp = 8'h99; shamt = 3'd1; dir = 1'b1;
        #3 check("hold_mid2", outp, held);
        rst = 1'b1;
        #2 check("hold_rst_mid", outp, held);
        rst = 1'b0; inp = 8'h81; shamt = 3'd3; dir = 1'b0;
        tick();
        check("hold_next", outp, 8'h0C);

        // Full sweep of amount and direction with random data.
        for (int kk = 0; kk < WIDTH; kk++) begin
            for (int dd = 0; dd < 2; dd++) begin
                for (int n = 0; n < 4; n++) begin
                    d = WIDTH'($urandom);
                    rst = 1'b0; inp = d; shamt = SHW'(kk); dir = dd[0];
                    tick();
                    check("sweep", outp, model_rot(d, kk, dd[0]));
                    checks++;
                    if ($countones(outp) != $countones(d)) begin
                        failures++;
                        $display("FAIL popcount: outp=%h inp=%h", outp, d);
                    end
                end
            end
        end

        // Fully random stream with occasional reset.
        for (int n = 0; n < 300; n++) begin
            d = WIDTH'($urandom);
            k = $urandom_range(0, WIDTH - 1);
            r = ($urandom_range(0, 15) == 0);
            rst = r; inp = d; shamt = SHW'(k); dir = 1'($urandom);
            e = r ? '0 : model_rot(d, k, dir);
            tick();
            check("random", outp, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
